reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_DEPTH, default 16: number of entries, power of two.
REQ-002 Parameter TAG_W, default 5: tag width; tag = entry index + 1, and tag 0 means "no producer".
REQ-003 clk_in  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_in  input  1  reset, asynchronous and active-low.
REQ-005 rdy_in  input  1  global enable; when low, all state and outputs hold.
REQ-006 alloc_valid_from_dispatcher  input  1  allocate one entry this cycle.
REQ-007 rd_from_dispatcher  input  5  destination register; 0 means no writeback.
REQ-008 pc_from_dispatcher  input  32  instruction PC.
REQ-009 is_branch_from_dispatcher, pred_taken_from_dispatcher  input  1 each  branch flag and predicted direction.
REQ-010 full_to_dispatcher  output  1  high when count == ROB_DEPTH.
REQ-011 tag_to_dispatcher  output  TAG_W  tag the next allocation will receive (tail + 1).
REQ-012 q1_from_dispatcher, q2_from_dispatcher  input  TAG_W  operand tags queried.
REQ-013 ready1_to_dispatcher, ready2_to_dispatcher  output  1; value1_to_dispatcher, value2_to_dispatcher  output  32  query results.
REQ-014 cdb_valid_in  input  1; cdb_tag_in  input  TAG_W; cdb_value_in  input  32; cdb_taken_in  input  1; cdb_target_in  input  32  result broadcast.
REQ-015 commit_flag_out  output  1; rd_to_register  output  5; V_to_register  output  32; Q_to_register  output  TAG_W  commit to the register file.
REQ-016 rollback_flag_out  output  1; rollback_pc_out  output  32  misprediction flush.

Function
REQ-017 Storage: circular buffer with head, tail and count (0..ROB_DEPTH); each entry holds busy, ready, rd, pc, is_branch, pred_taken, value, taken and target.
REQ-018 Allocation: on an edge where alloc_valid is high, full is low and no rollback is pending, the tail entry is written with busy=1 and ready=0, and tail advances modulo ROB_DEPTH.
REQ-019 Allocation while full is ignored, with no state change.
REQ-020 CDB write: when cdb_valid is high and the entry at cdb_tag-1 is busy, that entry's value, taken and target are stored and ready is set.
REQ-021 A CDB write with tag 0, or to a non-busy entry, is ignored.
REQ-022 Commit: at most one commit per cycle; when the head entry is busy and ready, the following are registered on the edge:
- commit_flag_out=1;
- rd_to_register=rd;
- V_to_register=value;
- Q_to_register=head+1.
The head entry is then freed and head advances.
REQ-023 commit_flag_out is a one-cycle pulse; on cycles without a commit, commit_flag_out=0 and rd_to_register=0.
REQ-024 Latency: CDB write at edge N gives commit_flag_out high after edge N+1 at the earliest.
REQ-025 Misprediction: a committing branch whose taken differs from pred_taken sets rollback_flag_out=1 on the same edge as its commit.
REQ-026 rollback_pc_out = target if taken, else pc+4.
REQ-027 On the edge following a rollback_flag_out pulse:
- all busy bits clear;
- head = tail = count = 0;
- any allocation or CDB write in that cycle is ignored.
REQ-028 Simultaneous allocation and commit: count stays unchanged.
REQ-029 full_to_dispatcher is derived from the registered count, so no allocation is accepted in the same cycle that a commit frees the last slot.
REQ-030 Head and tail wrap from ROB_DEPTH-1 to 0; the tag wraps from ROB_DEPTH to 1.
REQ-031 count never exceeds ROB_DEPTH and never underflows.

Reset
REQ-032 While rst_in is low, asynchronously:
- head, tail and count = 0;
- all busy and ready bits = 0;
- commit_flag_out and rollback_flag_out = 0;
- rd_to_register, Q_to_register, V_to_register and rollback_pc_out = 0.
After reset, full_to_dispatcher=0 and tag_to_dispatcher=1.
REQ-033 Reset asserted mid-operation discards all entries, including any pending rollback.

Configuration
REQ-034 Macro ROB_QUERY_BYPASS_EN.
- Defined: readyN_to_dispatcher=1 and valueN_to_dispatcher=entry value when qN is nonzero and the entry is busy and ready.
- Defined, combinational forwarding: if cdb_valid is high and cdb_tag==qN, the outputs are ready=1 and value=cdb_value_in.
- Not defined: ready1/2 are tied to 0 and value1/2 are tied to 0.

Verification
REQ-035 Reset; allocate rd=5; CDB tag 1 with value 0x1234 -> next cycle commit_flag=1, rd=5, V=0x1234, Q=1; count returns to 0.
REQ-036 Allocate 16 entries -> full=1; a 17th allocation is ignored; one commit frees a slot -> full=0; the next allocation gets tag 1 (wrap).
REQ-037 Complete tags 3, 2 and 1 out of order -> commits occur in order 1, 2, 3 on consecutive cycles.
REQ-038 Allocate a branch at pc=0x100 with pred_taken=1, then 2 more entries; CDB taken=0 -> rollback_flag=1 with rollback_pc=0x104; next cycle count=0 and tag=1.
REQ-039 With ROB_QUERY_BYPASS_EN defined: query q1=2 while the CDB broadcasts tag 2 with value 0xAA -> ready1=1 and value1=0xAA in the same cycle; without the macro -> ready1=0.
REQ-040 rdy_in low for 3 cycles during pending commits -> no state change; rst_in low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order commit queue with CDB writeback and branch rollback.
// Define ROB_QUERY_BYPASS_EN to enable operand-query lookup with CDB forwarding.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             alloc_valid_from_dispatcher,
  input  logic [4:0]       rd_from_dispatcher,
  input  logic [31:0]      pc_from_dispatcher,
  input  logic             is_branch_from_dispatcher,
  input  logic             pred_taken_from_dispatcher,
  output logic             full_to_dispatcher,
  output logic [TAG_W-1:0] tag_to_dispatcher,
  input  logic [TAG_W-1:0] q1_from_dispatcher,
  input  logic [TAG_W-1:0] q2_from_dispatcher,
  output logic             ready1_to_dispatcher,
  output logic             ready2_to_dispatcher,
  output logic [31:0]      value1_to_dispatcher,
  output logic [31:0]      value2_to_dispatcher,
  input  logic             cdb_valid_in,
  input  logic [TAG_W-1:0] cdb_tag_in,
  input  logic [31:0]      cdb_value_in,
  input  logic             cdb_taken_in,
  input  logic [31:0]      cdb_target_in,
  output logic             commit_flag_out,
  output logic [4:0]       rd_to_register,
  output logic [31:0]      V_to_register,
  output logic [TAG_W-1:0] Q_to_register,
  output logic             rollback_flag_out,
  output logic [31:0]      rollback_pc_out
);

  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [ROB_DEPTH-1:0] busy, ready;
  logic [ROB_DEPTH-1:0] br_mem, pred_mem, taken_mem;
  logic [4:0]           rd_mem     [ROB_DEPTH];
  logic [31:0]          pc_mem     [ROB_DEPTH];
  logic [31:0]          value_mem  [ROB_DEPTH];
  logic [31:0]          target_mem [ROB_DEPTH];
  logic [IDX_W-1:0]     head, tail;
  logic [CNT_W-1:0]     count;

  logic             cdb_hit, alloc_ok, commit_ok, mispredict;
  logic [IDX_W-1:0] cdb_idx;

  function automatic logic tag_in_range(input logic [TAG_W-1:0] t);
    return (t != '0) && (t <= TAG_W'(ROB_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
    return IDX_W'(t - TAG_W'(1));
  endfunction

  // A pending rollback (flag high) blocks every update except the flush itself.
  assign cdb_idx            = tag_idx(cdb_tag_in);
  assign cdb_hit            = cdb_valid_in && tag_in_range(cdb_tag_in) && busy[cdb_idx] && !rollback_flag_out;
  assign full_to_dispatcher = (count == CNT_W'(ROB_DEPTH));
  assign alloc_ok           = alloc_valid_from_dispatcher && !full_to_dispatcher && !rollback_flag_out;
  assign commit_ok          = busy[head] && ready[head] && !rollback_flag_out;
  assign mispredict         = br_mem[head] && (taken_mem[head] != pred_mem[head]);
  assign tag_to_dispatcher  = TAG_W'(tail) + TAG_W'(1);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      busy              <= '0;
      ready             <= '0;
      commit_flag_out   <= 1'b0;
      rd_to_register    <= '0;
      V_to_register     <= '0;
      Q_to_register     <= '0;
      rollback_flag_out <= 1'b0;
      rollback_pc_out   <= '0;
    end else if (rdy_in) begin
      commit_flag_out   <= commit_ok;
      rollback_flag_out <= commit_ok && mispredict;
      rd_to_register    <= commit_ok ? rd_mem[head] : 5'd0;
      if (commit_ok) begin
        V_to_register <= value_mem[head];
        Q_to_register <= TAG_W'(head) + TAG_W'(1);
      end
      if (commit_ok && mispredict)
        rollback_pc_out <= taken_mem[head] ? target_mem[head] : pc_mem[head] + 32'd4;

      if (rollback_flag_out) begin
        busy  <= '0;
        ready <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (alloc_ok) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + IDX_W'(1);
        end
        if (cdb_hit)
          ready[cdb_idx] <= 1'b1;
        if (commit_ok) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + IDX_W'(1);
        end
        if (alloc_ok && !commit_ok)
          count <= count + CNT_W'(1);
        else if (!alloc_ok && commit_ok)
          count <= count - CNT_W'(1);
      end
    end
  end

  // Payload storage needs no reset: busy/ready gate every read that matters.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (alloc_ok) begin
        rd_mem[tail]   <= rd_from_dispatcher;
        pc_mem[tail]   <= pc_from_dispatcher;
        br_mem[tail]   <= is_branch_from_dispatcher;
        pred_mem[tail] <= pred_taken_from_dispatcher;
      end
      if (cdb_hit) begin
        value_mem[cdb_idx]  <= cdb_value_in;
        taken_mem[cdb_idx]  <= cdb_taken_in;
        target_mem[cdb_idx] <= cdb_target_in;
      end
    end
  end

`ifdef ROB_QUERY_BYPASS_EN
  logic [IDX_W-1:0] q1_idx, q2_idx;

  assign q1_idx = tag_idx(q1_from_dispatcher);
  assign q2_idx = tag_idx(q2_from_dispatcher);

  always_comb begin
    ready1_to_dispatcher = 1'b0;
    value1_to_dispatcher = '0;
    if (cdb_valid_in && (q1_from_dispatcher != '0) && (cdb_tag_in == q1_from_dispatcher)) begin
      ready1_to_dispatcher = 1'b1;
      value1_to_dispatcher = cdb_value_in;
    end else if (tag_in_range(q1_from_dispatcher) && busy[q1_idx] && ready[q1_idx]) begin
      ready1_to_dispatcher = 1'b1;
      value1_to_dispatcher = value_mem[q1_idx];
    end
  end

  always_comb begin
    ready2_to_dispatcher = 1'b0;
    value2_to_dispatcher = '0;
    if (cdb_valid_in && (q2_from_dispatcher != '0) && (cdb_tag_in == q2_from_dispatcher)) begin
      ready2_to_dispatcher = 1'b1;
      value2_to_dispatcher = cdb_value_in;
    end else if (tag_in_range(q2_from_dispatcher) && busy[q2_idx] && ready[q2_idx]) begin
      ready2_to_dispatcher = 1'b1;
      value2_to_dispatcher = value_mem[q2_idx];
    end
  end
`else
  logic unused_query;

  assign unused_query         = ^{q1_from_dispatcher, q2_from_dispatcher};
  assign ready1_to_dispatcher = 1'b0;
  assign ready2_to_dispatcher = 1'b0;
  assign value1_to_dispatcher = '0;
  assign value2_to_dispatcher = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench for reorder_buffer: a queue-level model predicts each commit and its
// edge number; a separate monitor pops and compares whenever the DUT commit outputs update.
module tb_reorder_buffer;
  localparam int DEPTH = 16;
  localparam int TW    = 5;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          rdy_in = 1'b1;
  logic          alloc_valid = 1'b0;
  logic [4:0]    rd_d = '0;
  logic [31:0]   pc_d = '0;
  logic          isb_d = 1'b0;
  logic          pred_d = 1'b0;
  logic          full;
  logic [TW-1:0] tag_d;
  logic [TW-1:0] q1_d = '0;
  logic [TW-1:0] q2_d = '0;
  logic          ready1, ready2;
  logic [31:0]   value1, value2;
  logic          cdb_valid = 1'b0;
  logic [TW-1:0] cdb_tag = '0;
  logic [31:0]   cdb_value = '0;
  logic          cdb_taken = 1'b0;
  logic [31:0]   cdb_target = '0;
  logic          commit_flag_out;
  logic [4:0]    rd_to_register;
  logic [31:0]   V_to_register;
  logic [TW-1:0] Q_to_register;
  logic          rollback_flag_out;
  logic [31:0]   rollback_pc_out;

  reorder_buffer #(.ROB_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk_in                      (clk_in),
    .rst_in                      (rst_in),
    .rdy_in                      (rdy_in),
    .alloc_valid_from_dispatcher (alloc_valid),
    .rd_from_dispatcher          (rd_d),
    .pc_from_dispatcher          (pc_d),
    .is_branch_from_dispatcher   (isb_d),
    .pred_taken_from_dispatcher  (pred_d),
    .full_to_dispatcher          (full),
    .tag_to_dispatcher           (tag_d),
    .q1_from_dispatcher          (q1_d),
    .q2_from_dispatcher          (q2_d),
    .ready1_to_dispatcher        (ready1),
    .ready2_to_dispatcher        (ready2),
    .value1_to_dispatcher        (value1),
    .value2_to_dispatcher        (value2),
    .cdb_valid_in                (cdb_valid),
    .cdb_tag_in                  (cdb_tag),
    .cdb_value_in                (cdb_value),
    .cdb_taken_in                (cdb_taken),
    .cdb_target_in               (cdb_target),
    .commit_flag_out             (commit_flag_out),
    .rd_to_register              (rd_to_register),
    .V_to_register               (V_to_register),
    .Q_to_register               (Q_to_register),
    .rollback_flag_out           (rollback_flag_out),
    .rollback_pc_out             (rollback_pc_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [TW-1:0] tag;
    logic [4:0]    rd;
    logic [31:0]   pc;
    logic          isb;
    logic          pred;
    logic          rdy;
    logic [31:0]   val;
    logic          tk;
    logic [31:0]   tgt;
  } ent_t;

  typedef struct {
    int            cyc;
    logic [4:0]    rd;
    logic [31:0]   v;
    logic [TW-1:0] q;
    logic          rb;
    logic [31:0]   rbpc;
  } exp_t;

  ent_t m_rob[$];
  exp_t exp_q[$];
  int   m_next_tag = 1;
  bit   m_rb = 1'b0;

  int   cyc = 0;
  bit   last_en = 1'b0;
  bit   started = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic       prev_flag = 1'b0;
  logic [4:0] prev_rd = '0;
  logic       prev_rb = 1'b0;

  always @(posedge clk_in) begin
    cyc++;
    last_en = rdy_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of one enabled clock edge, evaluated on the values the DUT will sample.
  task automatic model_edge();
    ent_t h;
    exp_t e;
    ent_t n;
    bit   do_commit;
    bit   do_alloc;
    if (!rdy_in) return;
    if (m_rb) begin
      m_rob.delete();
      m_next_tag = 1;
      m_rb = 1'b0;
      return;
    end
    do_commit = (m_rob.size() > 0) && m_rob[0].rdy;
    do_alloc  = alloc_valid && (m_rob.size() < DEPTH);
    if (do_commit) begin
      h      = m_rob[0];
      e.cyc  = cyc + 1;
      e.rd   = h.rd;
      e.v    = h.val;
      e.q    = h.tag;
      e.rb   = h.isb && (h.tk != h.pred);
      e.rbpc = h.tk ? h.tgt : h.pc + 32'd4;
      exp_q.push_back(e);
      if (e.rb) m_rb = 1'b1;
    end
    if (cdb_valid) begin
      foreach (m_rob[i]) begin
        if (m_rob[i].tag == cdb_tag) begin
          m_rob[i].rdy = 1'b1;
          m_rob[i].val = cdb_value;
          m_rob[i].tk  = cdb_taken;
          m_rob[i].tgt = cdb_target;
        end
      end
    end
    if (do_commit) void'(m_rob.pop_front());
    if (do_alloc) begin
      n.tag  = TW'(m_next_tag);
      n.rd   = rd_d;
      n.pc   = pc_d;
      n.isb  = isb_d;
      n.pred = pred_d;
      n.rdy  = 1'b0;
      n.val  = '0;
      n.tk   = 1'b0;
      n.tgt  = '0;
      m_rob.push_back(n);
      m_next_tag = (m_next_tag == DEPTH) ? 1 : m_next_tag + 1;
    end
  endtask

`ifdef ROB_QUERY_BYPASS_EN
  function automatic void query_model(input logic [TW-1:0] q, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = '0;
    if (q == '0) return;
    if (cdb_valid && (cdb_tag == q)) begin
      r = 1'b1;
      v = cdb_value;
      return;
    end
    foreach (m_rob[i]) begin
      if ((m_rob[i].tag == q) && m_rob[i].rdy) begin
        r = 1'b1;
        v = m_rob[i].val;
      end
    end
  endfunction
`endif

  task automatic check_queries();
    logic        r1, r2;
    logic [31:0] v1, v2;
`ifdef ROB_QUERY_BYPASS_EN
    query_model(q1_d, r1, v1);
    query_model(q2_d, r2, v2);
`else
    r1 = 1'b0; v1 = '0;
    r2 = 1'b0; v2 = '0;
`endif
    chk("ready1", 32'(ready1), 32'(r1));
    chk("value1", value1, v1);
    chk("ready2", 32'(ready2), 32'(r2));
    chk("value2", value2, v2);
  endtask

  task automatic idle();
    rdy_in      = 1'b1;
    alloc_valid = 1'b0;
    rd_d        = '0;
    pc_d        = '0;
    isb_d       = 1'b0;
    pred_d      = 1'b0;
    q1_d        = '0;
    q2_d        = '0;
    cdb_valid   = 1'b0;
    cdb_tag     = '0;
    cdb_value   = '0;
    cdb_taken   = 1'b0;
    cdb_target  = '0;
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    #1;
    check_queries();
    model_edge();
    @(negedge clk_in);
    chk("full", 32'(full), 32'(m_rob.size() == DEPTH));
    chk("next_tag", 32'(tag_d), 32'(m_next_tag));
  endtask

  task automatic alloc_one(input logic [4:0] rd, input logic [31:0] pc, input logic isb, input logic pred);
    idle();
    alloc_valid = 1'b1;
    rd_d = rd; pc_d = pc; isb_d = isb; pred_d = pred;
    step();
  endtask

  task automatic cdb_one(input logic [TW-1:0] tag, input logic [31:0] val, input logic tk, input logic [31:0] tgt);
    idle();
    cdb_valid = 1'b1;
    cdb_tag = tag; cdb_value = val; cdb_taken = tk; cdb_target = tgt;
    step();
  endtask

  task automatic check_reset_outputs(input string lbl);
    chk({lbl, "_commit_flag"}, 32'(commit_flag_out), 32'd0);
    chk({lbl, "_rd"}, 32'(rd_to_register), 32'd0);
    chk({lbl, "_V"}, V_to_register, 32'd0);
    chk({lbl, "_Q"}, 32'(Q_to_register), 32'd0);
    chk({lbl, "_rollback_flag"}, 32'(rollback_flag_out), 32'd0);
    chk({lbl, "_rollback_pc"}, rollback_pc_out, 32'd0);
    chk({lbl, "_full"}, 32'(full), 32'd0);
    chk({lbl, "_tag"}, 32'(tag_d), 32'd1);
  endtask

  task automatic do_reset();
    #2 rst_in = 1'b0;
    #1 check_reset_outputs("rst");
    m_rob.delete();
    exp_q.delete();
    m_next_tag = 1;
    m_rb = 1'b0;
    prev_flag = 1'b0;
    prev_rd = '0;
    prev_rb = 1'b0;
    idle();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic drain();
    int idx;
    for (int i = 0; i < 200; i++) begin
      if (m_rob.size() == 0 && !m_rb) break;
      idle();
      idx = -1;
      foreach (m_rob[j]) if (idx < 0 && !m_rob[j].rdy) idx = j;
      if (idx >= 0) begin
        cdb_valid  = 1'b1;
        cdb_tag    = m_rob[idx].tag;
        cdb_value  = $urandom;
        cdb_taken  = m_rob[idx].pred;
        cdb_target = $urandom & 32'hFFFF_FFFC;
      end
      step();
    end
    idle();
    repeat (2) step();
  endtask

  task automatic random_cycle();
    int k;
    idle();
    rdy_in = ($urandom_range(0, 9) != 0);
    if ($urandom_range(0, 9) < 6) begin
      alloc_valid = 1'b1;
      rd_d   = 5'($urandom);
      pc_d   = $urandom & 32'hFFFF_FFFC;
      isb_d  = ($urandom_range(0, 7) == 0);
      pred_d = 1'($urandom_range(0, 1));
    end
    if ($urandom_range(0, 1) == 1) begin
      cdb_valid  = 1'b1;
      cdb_value  = $urandom;
      cdb_target = $urandom & 32'hFFFF_FFFC;
      if (m_rob.size() == 0 || $urandom_range(0, 4) == 0) begin
        cdb_tag   = TW'($urandom_range(0, DEPTH));
        cdb_taken = 1'($urandom_range(0, 1));
      end else begin
        k = $urandom_range(0, m_rob.size() - 1);
        cdb_tag   = m_rob[k].tag;
        cdb_taken = ($urandom_range(0, 4) == 0) ? ~m_rob[k].pred : m_rob[k].pred;
      end
    end
    q1_d = ($urandom_range(0, 3) == 0) ? cdb_tag : TW'($urandom_range(0, DEPTH));
    q2_d = TW'($urandom_range(0, DEPTH));
    step();
  endtask

  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (started && rst_in) begin
      if (last_en) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          chk("commit_cycle", 32'(cyc), 32'(exp_q[0].cyc));
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          chk("commit_flag", 32'(commit_flag_out), 32'd1);
          chk("commit_rd", 32'(rd_to_register), 32'(e.rd));
          chk("commit_V", V_to_register, e.v);
          chk("commit_Q", 32'(Q_to_register), 32'(e.q));
          chk("rollback_flag", 32'(rollback_flag_out), 32'(e.rb));
          if (e.rb) chk("rollback_pc", rollback_pc_out, e.rbpc);
          prev_flag = 1'b1;
          prev_rd   = e.rd;
          prev_rb   = e.rb;
        end else begin
          chk("idle_commit_flag", 32'(commit_flag_out), 32'd0);
          chk("idle_rd", 32'(rd_to_register), 32'd0);
          chk("idle_rollback_flag", 32'(rollback_flag_out), 32'd0);
          prev_flag = 1'b0;
          prev_rd   = '0;
          prev_rb   = 1'b0;
        end
      end else begin
        chk("hold_commit_flag", 32'(commit_flag_out), 32'(prev_flag));
        chk("hold_rd", 32'(rd_to_register), 32'(prev_rd));
        chk("hold_rollback_flag", 32'(rollback_flag_out), 32'(prev_rb));
      end
    end
  end

  initial begin
    idle();
    #3 rst_in = 1'b0;
    #1 check_reset_outputs("init");
    repeat (2) @(negedge clk_in);
    rst_in  = 1'b1;
    started = 1'b1;

    // single allocate / complete / commit
    alloc_one(5'd5, 32'h10, 1'b0, 1'b0);
    cdb_one(TW'(1), 32'h1234, 1'b0, 32'h0);
    idle(); step();
    chk("basic_V", V_to_register, 32'h1234);
    idle(); step();

    // fill to full, overflow attempt, free one slot, wrapped tag
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) alloc_one(5'(i + 1), 32'(i * 4), 1'b0, 1'b0);
    chk("full_after_fill", 32'(full), 32'd1);
    cdb_one(TW'(1), 32'hBEEF, 1'b0, 32'h0);
    idle(); step();
    chk("full_after_commit", 32'(full), 32'd0);
    chk("wrap_tag", 32'(tag_d), 32'd1);
    alloc_one(5'd7, 32'h400, 1'b0, 1'b0);
    drain();

    // out-of-order completion, in-order commit
    do_reset();
    for (int i = 0; i < 3; i++) alloc_one(5'(i + 10), 32'(32'h200 + i * 4), 1'b0, 1'b0);
    cdb_one(TW'(3), 32'h33, 1'b0, 32'h0);
    cdb_one(TW'(2), 32'h22, 1'b0, 32'h0);
    cdb_one(TW'(1), 32'h11, 1'b0, 32'h0);
    idle(); repeat (4) step();

    // mispredicted branch flushes the buffer
    do_reset();
    alloc_one(5'd1, 32'h100, 1'b1, 1'b1);
    alloc_one(5'd2, 32'h104, 1'b0, 1'b0);
    alloc_one(5'd3, 32'h108, 1'b0, 1'b0);
    cdb_one(TW'(1), 32'h0, 1'b0, 32'h500);
    idle(); step();
    chk("mispredict_flag", 32'(rollback_flag_out), 32'd1);
    chk("mispredict_pc", rollback_pc_out, 32'h104);
    idle(); step();
    chk("flush_tag", 32'(tag_d), 32'd1);
    chk("flush_full", 32'(full), 32'd0);
    idle(); step();

    // query forwarding from the CDB in the same cycle
    do_reset();
    alloc_one(5'd1, 32'h0, 1'b0, 1'b0);
    alloc_one(5'd2, 32'h4, 1'b0, 1'b0);
    idle();
    q1_d = TW'(2);
    cdb_valid = 1'b1; cdb_tag = TW'(2); cdb_value = 32'hAA;
    #1;
`ifdef ROB_QUERY_BYPASS_EN
    chk("bypass_ready1", 32'(ready1), 32'd1);
    chk("bypass_value1", value1, 32'hAA);
`else
    chk("bypass_ready1", 32'(ready1), 32'd0);
`endif
    step();
    drain();

    // global enable low while commits are pending
    do_reset();
    for (int i = 0; i < 3; i++) alloc_one(5'(i + 20), 32'(i * 4), 1'b0, 1'b0);
    cdb_one(TW'(1), 32'h101, 1'b0, 32'h0);
    cdb_one(TW'(2), 32'h202, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle();
      rdy_in = 1'b0;
      alloc_valid = 1'b1;
      cdb_valid = 1'b1; cdb_tag = TW'(3); cdb_value = 32'h303;
      step();
    end
    chk("stall_tag", 32'(tag_d), 32'd4);
    idle(); repeat (3) step();
    drain();

    // randomized traffic with a mid-stream reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      random_cycle();
      if (i == 1500) do_reset();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
